// File: rtl/idma_apb_cmd_seq.sv
// Buffers iDMA register writes in a command FIFO, issues each one on APB, then waits for the
// done interrupt and clears it. Optional interrupt-wait watchdog: define IDMA_APB_CMD_SEQ_TIMEOUT_EN.
module idma_apb_cmd_seq #(
    parameter int unsigned CMD_FIFO_DEPTH = 32'd8,
    parameter logic [11:0] INTR_CLR_ADDR  = 12'h000,
    parameter logic [31:0] INTR_CLR_DATA  = 32'h0000_0003,
    parameter int unsigned TIMEOUT_CYC    = 32'd65535
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        cmd_last,
    output logic [11:0] apb_PADDR,
    output logic        apb_PSEL,
    output logic        apb_PENABLE,
    output logic        apb_PWRITE,
    output logic [3:0]  apb_PSTRB,
    output logic [2:0]  apb_PPROT,
    output logic [31:0] apb_PWDATA,
    input  logic        apb_PREADY,
    input  logic        apb_PSLVERR,
    input  logic        interrupt,
    output logic        job_done,
    output logic [15:0] job_cnt,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);
    localparam int unsigned AW       = $clog2(CMD_FIFO_DEPTH);
    localparam logic [AW:0] CNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1'b1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(CMD_FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

    if ((CMD_FIFO_DEPTH < 32'd2) || ((CMD_FIFO_DEPTH & (CMD_FIFO_DEPTH - 32'd1)) != 32'd0) ||
        (TIMEOUT_CYC < 32'd1) || (TIMEOUT_CYC > 32'd65535)) begin : g_bad_param
        $error("idma_apb_cmd_seq: illegal CMD_FIFO_DEPTH or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_ACCESS     = 3'd2,
        ST_WAIT_INTR  = 3'd3,
        ST_CLR_SETUP  = 3'd4,
        ST_CLR_ACCESS = 3'd5
    } state_t;

    logic [44:0]   fifo_mem_r [CMD_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_nxt_s;
    state_t        state_r, state_nxt_s;
    logic          push_s, pop_s, clr_done_s, err_set_s, timeout_s, wdog_expired_s, remain_s;
    logic [44:0]   head_s;
    logic [43:0]   head_nxt_s;
    logic          cmd_ready_r, psel_r, penable_r, job_done_r, busy_r, err_r;
    logic [11:0]   paddr_r;
    logic [31:0]   pwdata_r;
    logic [15:0]   job_cnt_r;

    assign push_s      = cmd_valid && cmd_ready_r;
    assign pop_s       = (state_r == ST_ACCESS) && apb_PREADY;
    assign clr_done_s  = (state_r == ST_CLR_ACCESS) && apb_PREADY;
    assign count_nxt_s = count_r + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    // Next SETUP presents the entry that will be at the head once this cycle's pop retires.
    assign head_nxt_s  = pop_s ? fifo_mem_r[rd_ptr_r + PTR_ONE][43:0] : head_s[43:0];
    assign remain_s    = pop_s ? (count_r > CNT_ONE) : (count_r != CNT_ZERO);
    assign err_set_s   = (psel_r && penable_r && apb_PREADY && apb_PSLVERR) || timeout_s;

`ifdef IDMA_APB_CMD_SEQ_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 32'd1);
    logic [15:0] wdog_r;

    // Watchdog counts consecutive WAIT_INTR cycles and restarts from zero on every exit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wdog_r <= 16'h0000;
        end else if ((state_r == ST_WAIT_INTR) && (state_nxt_s == ST_WAIT_INTR)) begin
            wdog_r <= wdog_r + 16'h0001;
        end else begin
            wdog_r <= 16'h0000;
        end
    end

    assign wdog_expired_s = (wdog_r == WDOG_LAST);
`else
    assign wdog_expired_s = 1'b0;
`endif

    // Command storage; no reset needed because count_r gates every read.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_last, cmd_addr, cmd_data};
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= CNT_ZERO;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r     <= count_nxt_s;
            cmd_ready_r <= (count_nxt_s != CNT_FULL);
        end
    end

    // Next-state logic for the APB write / interrupt handshake sequence.
    always_comb begin
        state_nxt_s = state_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != CNT_ZERO) state_nxt_s = ST_SETUP;
                else                     state_nxt_s = ST_IDLE;
            end
            ST_SETUP:     state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (!apb_PREADY)    state_nxt_s = ST_ACCESS;
                else if (head_s[44]) state_nxt_s = ST_WAIT_INTR;
                else if (remain_s)   state_nxt_s = ST_SETUP;
                else                 state_nxt_s = ST_IDLE;
            end
            ST_WAIT_INTR: begin
                if (interrupt) begin
                    state_nxt_s = ST_CLR_SETUP;
                end else if (wdog_expired_s) begin
                    state_nxt_s = ST_CLR_SETUP;
                    timeout_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_INTR;
                end
            end
            ST_CLR_SETUP: state_nxt_s = ST_CLR_ACCESS;
            ST_CLR_ACCESS: begin
                if (!apb_PREADY)  state_nxt_s = ST_CLR_ACCESS;
                else if (remain_s) state_nxt_s = ST_SETUP;
                else               state_nxt_s = ST_IDLE;
            end
            default:      state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus APB and status outputs, all registered from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r    <= ST_IDLE;
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            paddr_r    <= 12'h000;
            pwdata_r   <= 32'h0000_0000;
            job_done_r <= 1'b0;
            job_cnt_r  <= 16'h0000;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            psel_r    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS) ||
                         (state_nxt_s == ST_CLR_SETUP) || (state_nxt_s == ST_CLR_ACCESS);
            penable_r <= (state_nxt_s == ST_ACCESS) || (state_nxt_s == ST_CLR_ACCESS);
            if (state_nxt_s == ST_SETUP) begin
                paddr_r  <= head_nxt_s[43:32];
                pwdata_r <= head_nxt_s[31:0];
            end else if (state_nxt_s == ST_CLR_SETUP) begin
                paddr_r  <= INTR_CLR_ADDR;
                pwdata_r <= INTR_CLR_DATA;
            end
            job_done_r <= clr_done_s;
            if (clr_done_s) job_cnt_r <= job_cnt_r + 16'h0001;
            busy_r <= (state_nxt_s != ST_IDLE) || (count_nxt_s != CNT_ZERO);
            if (err_set_s)    err_r <= 1'b1;
            else if (err_clr) err_r <= 1'b0;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign apb_PADDR   = paddr_r;
    assign apb_PSEL    = psel_r;
    assign apb_PENABLE = penable_r;
    assign apb_PWRITE  = 1'b1;
    assign apb_PSTRB   = 4'hF;
    assign apb_PPROT   = 3'b000;
    assign apb_PWDATA  = pwdata_r;
    assign job_done    = job_done_r;
    assign job_cnt     = job_cnt_r;
    assign busy        = busy_r;
    assign err         = err_r;

endmodule

// File: tb/tb_idma_apb_cmd_seq.sv
// Scoreboard bench for idma_apb_cmd_seq: directed command streams, APB writes checked by a monitor.
module tb_idma_apb_cmd_seq;
    localparam logic [11:0] CLR_ADDR = 12'h000;
    localparam logic [31:0] CLR_DATA = 32'h0000_0003;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_last;
    logic [11:0] cmd_addr, apb_PADDR;
    logic [31:0] cmd_data, apb_PWDATA;
    logic        apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PREADY, apb_PSLVERR;
    logic [3:0]  apb_PSTRB;
    logic [2:0]  apb_PPROT;
    logic        interrupt, job_done, busy, err, err_clr;
    logic [15:0] job_cnt;

    int n_tests = 0, n_fail = 0;
    logic [43:0] exp_q[$];
    int  xfer_cnt = 0, slverr_idx = 0;
    logic slverr_en = 1'b0;
    int  psel_cycles = 0, setup_cycles = 0, access_cycles = 0, jobs_seen = 0, wait_cycles = 0;
    logic prev_setup = 1'b0, prev_wait = 1'b0, prev_done = 1'b0;
    logic [11:0] prev_addr = 12'h000;
    logic [31:0] prev_data = 32'h0;

    assign apb_PSLVERR = slverr_en && (xfer_cnt == slverr_idx);

    idma_apb_cmd_seq #(.CMD_FIFO_DEPTH(8), .INTR_CLR_ADDR(CLR_ADDR), .INTR_CLR_DATA(CLR_DATA),
                       .TIMEOUT_CYC(100)) dut (
        .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
        .apb_PWRITE(apb_PWRITE), .apb_PSTRB(apb_PSTRB), .apb_PPROT(apb_PPROT),
        .apb_PWDATA(apb_PWDATA), .apb_PREADY(apb_PREADY), .apb_PSLVERR(apb_PSLVERR),
        .interrupt(interrupt), .job_done(job_done), .job_cnt(job_cnt), .busy(busy),
        .err(err), .err_clr(err_clr));

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completed-transfer index, advanced at the same edge the DUT samples PREADY.
    always @(posedge aclk) begin
        if (aresetn && apb_PSEL && apb_PENABLE && apb_PREADY) xfer_cnt <= xfer_cnt + 1;
    end

    // Monitor: scoreboard pop per APB completion, phase/stability checks, job_done checks.
    always @(negedge aclk) begin
        logic [43:0] e;
        if (!aresetn) begin
            prev_setup = 1'b0; prev_wait = 1'b0; prev_done = 1'b0; jobs_seen = 0;
        end else begin
            if (apb_PSEL && apb_PENABLE) begin
                check("apb_phase_stable",
                      64'({(prev_setup || prev_wait), prev_addr, prev_data}),
                      64'({1'b1, apb_PADDR, apb_PWDATA}));
                access_cycles++;
                if (apb_PREADY) begin
                    if (exp_q.size() == 0) begin
                        check("apb_unexpected_write", 64'({apb_PADDR, apb_PWDATA}), 64'h0);
                        n_fail += (n_fail == 0 && apb_PADDR == 12'h0 && apb_PWDATA == 32'h0) ? 1 : 0;
                    end else begin
                        e = exp_q.pop_front();
                        check("apb_write",
                              64'({apb_PWRITE, apb_PSTRB, apb_PPROT, apb_PADDR, apb_PWDATA}),
                              64'({1'b1, 4'hF, 3'b000, e}));
                    end
                end
            end
            if (apb_PSEL) psel_cycles++;
            if (apb_PSEL && !apb_PENABLE) setup_cycles++;
            if (job_done) begin
                jobs_seen++;
                check("job_cnt_on_done", 64'(job_cnt), 64'(jobs_seen));
                check("job_done_pulse", 64'(prev_done), 64'd0);
            end
            prev_setup = apb_PSEL && !apb_PENABLE;
            prev_wait  = apb_PSEL && apb_PENABLE && !apb_PREADY;
            prev_addr  = apb_PADDR;
            prev_data  = apb_PWDATA;
            prev_done  = job_done;
        end
    end

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    task automatic push(input logic [11:0] a, input logic [31:0] d, input logic l);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge aclk); ok = cmd_ready;
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back({a, d});
        else check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name, input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_access();
        for (int i = 0; i < 30 && !(apb_PSEL && apb_PENABLE); i++) tick();
        check("reach_access", 64'({apb_PSEL, apb_PENABLE}), 64'd3);
    endtask

    task automatic wait_done(input string name, input int lim);
        for (int i = 0; i < lim && !job_done; i++) tick();
        check(name, 64'(job_done), 64'd1);
    endtask

    task automatic raise_intr();
        exp_q.push_back({CLR_ADDR, CLR_DATA});
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_addr = 12'h0; cmd_data = 32'h0; cmd_last = 1'b0;
        apb_PREADY = 1'b1; interrupt = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_apb", 64'({apb_PSEL, apb_PENABLE, apb_PADDR, apb_PWDATA}), 64'd0);
        check("rst_status", 64'({cmd_ready, job_done, job_cnt, busy, err}), 64'({1'b1, 19'd0}));
        aresetn = 1'b1;
        tick();

        // Interrupt while idle must do nothing
        interrupt = 1'b1;
        repeat (3) tick();
        interrupt = 1'b0;
        tick();
        check("intr_idle_ignored", 64'({busy, apb_PSEL, job_cnt}), 64'd0);

        // Basic job: three writes then interrupt clear
        psel_cycles = 0; setup_cycles = 0;
        push(12'h010, 32'h0000_000A, 1'b0);
        push(12'h014, 32'h0000_000B, 1'b0);
        push(12'h000, 32'h0000_0001, 1'b1);
        wait_drain("job1_writes", 40);
        repeat (3) tick();
        check("job1_psel_cycles", 64'(psel_cycles), 64'd6);
        check("job1_setup_cycles", 64'(setup_cycles), 64'd3);
        check("job1_wait_intr", 64'({busy, apb_PSEL, job_cnt}), 64'({1'b1, 1'b0, 16'd0}));
        raise_intr();
        wait_done("job1_done", 20);
        check("job1_cnt", 64'(job_cnt), 64'd1);
        check("job1_clr_psel_cycles", 64'(psel_cycles), 64'd8);
        repeat (2) tick();
        check("job1_idle", 64'({busy, job_done}), 64'd0);

        // PREADY low for 5 ACCESS cycles
        access_cycles = 0; apb_PREADY = 1'b0;
        push(12'h020, 32'h0000_00C0, 1'b0);
        wait_access();
        repeat (5) tick();
        apb_PREADY = 1'b1;
        wait_drain("wait_state_write", 10);
        check("wait_state_access_cycles", 64'(access_cycles), 64'd6);
        repeat (2) tick();
        check("wait_state_idle", 64'(busy), 64'd0);

        // Nine pushes into a depth-8 FIFO with the slave stalled
        apb_PREADY = 1'b0;
        for (int i = 0; i < 8; i++) push(12'h100 + 12'(4 * i), 32'h1000 + 32'(i), 1'b0);
        check("fifo_full_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b1; cmd_addr = 12'h120; cmd_data = 32'h0000_1008; cmd_last = 1'b0;
        repeat (4) tick();
        check("fifo_full_hold", 64'({cmd_ready, 8'(exp_q.size())}), 64'({1'b0, 8'd8}));
        apb_PREADY = 1'b1;
        push(12'h120, 32'h0000_1008, 1'b0);
        wait_drain("fifo_writes", 60);
        repeat (2) tick();
        check("fifo_idle", 64'(busy), 64'd0);

        // PSLVERR on the second write
        check("err_before", 64'(err), 64'd0);
        slverr_idx = xfer_cnt + 1; slverr_en = 1'b1;
        push(12'h030, 32'h0000_0011, 1'b0);
        push(12'h034, 32'h0000_0022, 1'b0);
        push(12'h000, 32'h0000_0001, 1'b1);
        wait_drain("slverr_writes", 40);
        slverr_en = 1'b0;
        check("err_set", 64'(err), 64'd1);
        repeat (5) tick();
        check("err_sticky", 64'(err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", 64'(err), 64'd0);
        // Error on the clear write while err_clr is held: set must win
        err_clr = 1'b1; slverr_idx = xfer_cnt; slverr_en = 1'b1;
        raise_intr();
        wait_done("job2_done", 20);
        err_clr = 1'b0; slverr_en = 1'b0;
        check("err_set_wins", 64'(err), 64'd1);
        check("job2_cnt", 64'(job_cnt), 64'd2);

`ifdef IDMA_APB_CMD_SEQ_TIMEOUT_EN
        // Watchdog: interrupt never arrives
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        push(12'h044, 32'h0000_0077, 1'b1);
        exp_q.push_back({CLR_ADDR, CLR_DATA});
        wait_access();
        wait_cycles = 0;
        for (int i = 0; i < 300 && !job_done; i++) begin
            tick();
            if (busy && !apb_PSEL && !job_done) wait_cycles++;
        end
        check("timeout_done", 64'(job_done), 64'd1);
        check("timeout_wait_cycles", 64'(wait_cycles), 64'd100);
        check("timeout_err_cnt", 64'({err, job_cnt}), 64'({1'b1, 16'd3}));
        wait_drain("timeout_clr_write", 5);
`endif

        // Reset asserted in the middle of an ACCESS phase
        apb_PREADY = 1'b0;
        push(12'h050, 32'h0000_5A5A, 1'b0);
        push(12'h054, 32'h0000_A5A5, 1'b0);
        wait_access();
        aresetn = 1'b0;
        #1;
        check("rst_abort_apb", 64'({apb_PSEL, apb_PENABLE, apb_PADDR, apb_PWDATA}), 64'd0);
        check("rst_abort_status", 64'({cmd_ready, job_cnt, busy, err}), 64'({1'b1, 18'd0}));
        exp_q.delete();
        tick();
        aresetn = 1'b1; apb_PREADY = 1'b1;
        repeat (6) tick();
        check("post_rst_fifo_empty", 64'({busy, apb_PSEL, cmd_ready}), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
